// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Brief    : Power-of-two synchronous FIFO for UART TX/RX paths with level,
//            thresholds, sticky errors and flush. Define UART_FIFO_FWFT_EN
//            for first-word fall-through read data.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_data_wr,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_data_rd,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] c_LVL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_set;
  logic w_udf_set;

  // Flags come only from the registered level, so they never see wr_en/rd_en.
  assign w_full  = (r_level == c_DEPTH);
  assign w_empty = (r_level == '0);

  // Flush swallows both requests entirely, including their error side effects.
  assign w_wr_acc  = i_wr_en && !w_full  && !i_flush;
  assign w_rd_acc  = i_rd_en && !w_empty && !i_flush;
  assign w_ovf_set = i_wr_en && w_full  && !i_flush;
  assign w_udf_set = i_rd_en && w_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  && !i_clr_err) || w_ovf_set;
      r_underflow <= (r_underflow && !i_clr_err) || w_udf_set;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        case ({w_wr_acc, w_rd_acc})
          2'b10:   r_level <= r_level + c_LVL_ONE;
          2'b01:   r_level <= r_level - c_LVL_ONE;
          default: r_level <= r_level;
        endcase
      end
    end
  end

`ifdef UART_FIFO_FWFT_EN
  assign o_data_rd = r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_data_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_rd <= '0;
    end else if (w_rd_acc) begin
      r_data_rd <= r_mem[r_rd_ptr];
    end
  end

  assign o_data_rd = r_data_rd;
`endif

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_level >= c_AFULL);
  assign o_almost_empty = (r_level <= c_AEMPTY);
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Brief    : Self-checking bench for uart_fifo_ctrl against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [DW-1:0] i_data_wr = '0;
  logic          i_rd_en = 1'b0;
  logic          i_clr_err = 1'b0;
  logic [DW-1:0] o_data_rd;
  logic          o_full, o_empty, o_almost_full, o_almost_empty;
  logic [AW:0]   o_level;
  logic          o_overflow, o_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          chk_en = 1'b0;

  uart_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_wr_en(i_wr_en),
    .i_data_wr(i_data_wr), .i_rd_en(i_rd_en), .o_data_rd(o_data_rd),
    .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
    .o_almost_empty(o_almost_empty), .o_level(o_level), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .i_clr_err(i_clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Applies the request rules to the queue, using inputs as sampled at the edge.
  task automatic model_edge();
    bit was_full, was_empty, set_o, set_u;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    set_o = 0;
    set_u = 0;
    if (i_flush) begin
      q.delete();
    end else begin
      set_o = i_wr_en && was_full;
      set_u = i_rd_en && was_empty;
      if (i_rd_en && !was_empty) m_data = q.pop_front();
      if (i_wr_en && !was_full)  q.push_back(i_data_wr);
    end
    m_ovf = (m_ovf && !i_clr_err) || set_o;
    m_udf = (m_udf && !i_clr_err) || set_u;
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                      input bit fl, input bit ce);
    i_wr_en = wr; i_data_wr = d; i_rd_en = rd; i_flush = fl; i_clr_err = ce;
    @(posedge clk);
    model_edge();
    #1;
    i_wr_en = 0; i_rd_en = 0; i_flush = 0; i_clr_err = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("level",        int'(o_level),        q.size());
      check("full",         int'(o_full),         int'(q.size() == DEPTH));
      check("empty",        int'(o_empty),        int'(q.size() == 0));
      check("almost_full",  int'(o_almost_full),  int'(q.size() >= AFULL));
      check("almost_empty", int'(o_almost_empty), int'(q.size() <= AEMPTY));
      check("overflow",     int'(o_overflow),     int'(m_ovf));
      check("underflow",    int'(o_underflow),    int'(m_udf));
`ifdef UART_FIFO_FWFT_EN
      if (q.size() != 0) check("data_rd", int'(o_data_rd), int'(q[0]));
`else
      check("data_rd",      int'(o_data_rd),      int'(m_data));
`endif
    end
  end

  initial begin
    logic [DW-1:0] v;
    #1;
    check("rst_level", int'(o_level), 0);
    check("rst_empty", int'(o_empty), 1);
    check("rst_full",  int'(o_full), 0);
    check("rst_aempty", int'(o_almost_empty), 1);
    check("rst_data",  int'(o_data_rd), 0);
    @(negedge clk);
    reset = 0;
    chk_en = 1;

    // 1: fill and drain in order
    for (int i = 0; i < 8; i++) step(1, 8'(8'h11 * (i + 1)), 0, 0, 0);
    check("t1_level8", int'(o_level), 8);
    check("t1_full", int'(o_full), 1);
    for (int i = 0; i < 8; i++) begin
`ifdef UART_FIFO_FWFT_EN
      check("t1_data", int'(o_data_rd), int'(8'(8'h11 * (i + 1))));
      step(0, 0, 1, 0, 0);
`else
      step(0, 0, 1, 0, 0);
      check("t1_data", int'(o_data_rd), int'(8'(8'h11 * (i + 1))));
`endif
    end
    check("t1_empty", int'(o_empty), 1);

    // 2: overflow
    for (int i = 0; i < 8; i++) step(1, 8'(i + 1), 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    check("t2_ovf", int'(o_overflow), 1);
    check("t2_level", int'(o_level), 8);
    for (int i = 0; i < 8; i++) begin
`ifdef UART_FIFO_FWFT_EN
      check("t2_data", int'(o_data_rd), i + 1);
      step(0, 0, 1, 0, 0);
`else
      step(0, 0, 1, 0, 0);
      check("t2_data", int'(o_data_rd), i + 1);
`endif
    end
    step(0, 0, 0, 0, 1);
    check("t2_clr", int'(o_overflow), 0);

    // 3: concurrent read/write at level 4, then empty + both
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h24 + i), 1, 0, 0);
    check("t3_level4", int'(o_level), 4);
`ifndef UART_FIFO_FWFT_EN
    check("t3_last_rd", int'(o_data_rd), 8'h29);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    check("t3_level1", int'(o_level), 1);
    check("t3_udf", int'(o_underflow), 1);
    step(0, 0, 1, 0, 1);

    // 4: thresholds
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 1) check("t4_ae_at2", int'(o_almost_empty), 1);
      if (i == 2) check("t4_ae_at3", int'(o_almost_empty), 0);
      if (i == 4) check("t4_af_at5", int'(o_almost_full), 0);
      if (i == 5) check("t4_af_at6", int'(o_almost_full), 1);
    end

    // 5: flush at level 5, then reset mid-burst
    step(0, 0, 1, 0, 0);
    check("t5_level5", int'(o_level), 5);
    step(1, 8'hEE, 0, 1, 0);
    check("t5_flush_level", int'(o_level), 0);
    check("t5_flush_empty", int'(o_empty), 1);
    step(1, 8'h31, 0, 0, 0);
    step(1, 8'h32, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    i_wr_en = 1; i_data_wr = 8'h33;
    @(posedge clk);
    #3 reset = 1;
    #1;
    check("t5_rst_level", int'(o_level), 0);
    check("t5_rst_empty", int'(o_empty), 1);
    check("t5_rst_full", int'(o_full), 0);
    check("t5_rst_ae", int'(o_almost_empty), 1);
    check("t5_rst_af", int'(o_almost_full), 0);
    check("t5_rst_err", int'({o_overflow, o_underflow}), 0);
    check("t5_rst_data", int'(o_data_rd), 0);
    model_reset();
    i_wr_en = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;

    // 6: single word latency
    step(1, 8'hA5, 0, 0, 0);
`ifdef UART_FIFO_FWFT_EN
    check("t6_fwft_data", int'(o_data_rd), 8'hA5);
    step(0, 0, 1, 0, 0);
    check("t6_empty", int'(o_empty), 1);
`else
    step(0, 0, 1, 0, 0);
    check("t6_std_data", int'(o_data_rd), 8'hA5);
`endif

    // Random traffic: write-heavy then read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 70 : 35;
      v  = 8'($urandom);
      step($urandom_range(99) < wp, v, $urandom_range(99) < (100 - wp),
           $urandom_range(59) == 0, $urandom_range(24) == 0);
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
